branch_pred_unit: RTL and testbench
===================================

Name: branch_pred_unit

Overview:
Parametrised branch prediction unit for the 5-stage pipeline. It replaces the fixed "predict not-taken, flush on taken" policy with a direct-mapped branch target buffer (BTB) that holds a 2-bit saturating counter per entry.
- Fetch performs a same-cycle lookup on the IF-stage PC.
- EX returns the resolved outcome. The block detects mispredictions, produces the redirect PC, updates the table and keeps performance counters.

Parameters:
XLEN, 32, datapath/PC width
ENTRIES, 64, BTB entries; must be a power of two, >= 2
CTR_W, 2, saturating counter width
PERF_W, 32, performance counter width
(derived) IDX_W = $clog2(ENTRIES); TAG_W = XLEN-IDX_W-2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
pc_if  in  XLEN  fetch PC to look up
pred_hit  out  1  valid entry with matching tag for pc_if
pred_taken  out  1  prediction for pc_if
pred_target  out  XLEN  predicted target (meaningful only when pred_taken)
upd_valid  in  1  EX reports a resolved instruction this cycle
upd_pc  in  XLEN  PC of the resolved instruction
upd_is_cf  in  1  instruction is a branch or jump
upd_uncond  in  1  instruction is an unconditional jump (jal/jalr)
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target
upd_pred_taken  in  1  prediction carried down the pipe with this instruction
upd_pred_target  in  XLEN  predicted target carried down the pipe
mispredict  out  1  flush IF/ID and redirect fetch
redirect_pc  out  XLEN  correct next PC
perf_cf  out  PERF_W  count of resolved control-flow instructions
perf_miss  out  PERF_W  count of mispredictions

Behaviour:
- Lookup address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[XLEN-1:IDX_W+2]
  - Entry fields: valid, tag, target, ctr, uncond.
- Lookup is combinational from pc_if (asynchronous array read, zero latency).
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (uncond | ctr[CTR_W-1]).
  - pred_target = entry target.
- Mispredict detection is combinational and qualified by upd_valid:
  - Case a: upd_is_cf and upd_taken != upd_pred_taken.
  - Case b: upd_is_cf, both taken, and upd_target != upd_pred_target.
  - Case c: !upd_is_cf and upd_pred_taken (stale entry).
- redirect_pc = (upd_is_cf & upd_taken) ? upd_target : upd_pc+4. redirect_pc is valid only when mispredict=1.
- Table update is registered (visible from the next cycle), applied when upd_valid.
  - CF hit: ctr saturating +1 if taken, -1 if not taken, never wraps. If taken, target <= upd_target. uncond <= upd_uncond.
  - CF miss, taken: allocate and overwrite (evict) whatever occupies the index. valid=1, tag, target. ctr = weakly taken (10), or strongly taken (11) if upd_uncond.
  - CF miss, not taken: no allocation.
  - Non-CF with a hit: clear valid.
  - Non-CF without a hit: no change.
  - An unconditional jump that is updated with not taken is treated as a conditional update.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. No bypass.
- Perf counters:
  - perf_cf increments on upd_valid & upd_is_cf.
  - perf_miss increments on mispredict.
  - Both saturate at all-ones.
- Reset, in one cycle:
  - All valid bits = 0, all ctr = 01.
  - perf_cf = perf_miss = 0.
  - Target and tag fields are don't-care.
- While rst=1, pred_hit, pred_taken and mispredict are forced to 0, and pred_target and redirect_pc are forced to 0. Updates are ignored.
- A reset in the same cycle as an update: reset wins.
- Stall handling is external. The PC holds, so the lookup result stays stable.

Decomposition:
- Package bpu_pkg holds:
  - Counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - Typedef btb_entry_t (parametrised via the module using a local struct or a packed-field convention).
  - Function ctr_next(ctr, taken) implementing the saturation rule.
- No sub-module is required. The perf counters may be factored into a sat_counter sub-module instantiated twice.

Test Plan:
1. Reset, then pc_if=0x100 -> pred_hit=0, pred_taken=0, perf_cf=0, perf_miss=0.
2. Update pc=0x100, cf, taken, target=0x80, pred_taken=0 -> mispredict=1, redirect_pc=0x80, perf_miss=1. Next cycle pc_if=0x100 -> hit=1, taken=1, target=0x80.
3. Three not-taken updates at 0x100 with the carried prediction matching the table:
   - Counter goes 10->01->00->00 (saturates).
   - First update: mispredict=1, redirect_pc=0x104.
   - Afterwards pred_taken=0.
4. Allocate 0x100 taken to 0x80, then allocate 0x200 (same index 0) taken to 0x300 -> lookup 0x100: hit=0; lookup 0x200: target=0x300.
5. Same cycle: pc_if=0x40 with an allocating update at 0x40 -> pred_hit=0 that cycle, pred_hit=1 the next cycle.
6. jal at 0x40 to 0x400 (uncond), then a non-CF update at 0x40 with upd_pred_taken=1 -> mispredict=1, redirect_pc=0x44, entry invalidated, perf_cf=1, perf_miss=2.

Source files
------------

// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// bpu_pkg : shared counter encodings and saturation helper for the predictor
// Rev 1.0
// ============================================================================
package bpu_pkg;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Counters up to 8 bits wide are carried through this helper.
  function automatic logic [7:0] ctr_next(input logic [7:0] ctr,
                                          input logic [7:0] ctr_max,
                                          input logic       taken);
    if (taken) return (ctr == ctr_max) ? ctr : ctr + 8'd1;
    else       return (ctr == 8'(CTR_SNT)) ? ctr : ctr - 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_pred_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : event counter that holds at all-ones instead of wrapping
// Rev 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (en && (r_count != '1))
      r_count <= r_count + W'(1);
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_pred_unit.sv
`default_nettype none
// ============================================================================
// branch_pred_unit : direct-mapped BTB with saturating counters, redirect and
//                    performance counting for the 5-stage pipeline
// Rev 1.0
// ============================================================================
module branch_pred_unit
  import bpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_if,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_cf,
  input  logic              upd_uncond,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [PERF_W-1:0] perf_cf,
  output logic [PERF_W-1:0] perf_miss
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  // Stretch a 2-bit counter encoding to CTR_W bits, keeping its weak/strong meaning.
  function automatic logic [CTR_W-1:0] ctr_const(input logic [1:0] k);
    logic [CTR_W-1:0] low;
    low = (CTR_W'(1) << (CTR_W - 2)) - CTR_W'(1);
    return (CTR_W'(k) << (CTR_W - 2)) | (k[0] ? low : '0);
  endfunction

  localparam logic [CTR_W-1:0] c_ctr_wnt = ctr_const(CTR_WNT);
  localparam logic [CTR_W-1:0] c_ctr_wt  = ctr_const(CTR_WT);
  localparam logic [CTR_W-1:0] c_ctr_st  = ctr_const(CTR_ST);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [CTR_W-1:0] ctr;
    logic             uncond;
  } btb_entry_t;

  btb_entry_t r_btb [ENTRIES];

  logic [IDX_W-1:0] w_lidx;
  logic [TAG_W-1:0] w_ltag;
  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_lhit;
  logic             w_uhit;
  logic             w_miss;
  logic             w_unused_pc;

  assign w_lidx      = pc_if[IDX_W+1:2];
  assign w_ltag      = pc_if[XLEN-1:IDX_W+2];
  assign w_uidx      = upd_pc[IDX_W+1:2];
  assign w_utag      = upd_pc[XLEN-1:IDX_W+2];
  assign w_unused_pc = ^pc_if[1:0];

  // Lookup reads the array directly; a same-cycle update is not bypassed.
  assign w_lhit = r_btb[w_lidx].valid && (r_btb[w_lidx].tag == w_ltag);
  assign w_uhit = r_btb[w_uidx].valid && (r_btb[w_uidx].tag == w_utag);

  assign pred_hit    = !rst && w_lhit;
  assign pred_taken  = !rst && w_lhit && (r_btb[w_lidx].uncond || r_btb[w_lidx].ctr[CTR_W-1]);
  assign pred_target = rst ? '0 : r_btb[w_lidx].target;

  assign w_miss = upd_valid && (
                    (upd_is_cf && (upd_taken != upd_pred_taken)) ||
                    (upd_is_cf && upd_taken && upd_pred_taken &&
                     (upd_target != upd_pred_target)) ||
                    (!upd_is_cf && upd_pred_taken));

  assign mispredict  = !rst && w_miss;
  assign redirect_pc = rst ? '0 :
                       (upd_is_cf && upd_taken) ? upd_target : upd_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb[i].valid <= 1'b0;
        r_btb[i].ctr   <= c_ctr_wnt;
      end
    end else if (upd_valid) begin
      if (upd_is_cf) begin
        if (w_uhit) begin
          r_btb[w_uidx].ctr    <= CTR_W'(ctr_next(8'(r_btb[w_uidx].ctr), 8'(c_ctr_st), upd_taken));
          r_btb[w_uidx].uncond <= upd_uncond;
          if (upd_taken)
            r_btb[w_uidx].target <= upd_target;
        end else if (upd_taken) begin
          // Allocation evicts whatever currently owns the index.
          r_btb[w_uidx].valid  <= 1'b1;
          r_btb[w_uidx].tag    <= w_utag;
          r_btb[w_uidx].target <= upd_target;
          r_btb[w_uidx].uncond <= upd_uncond;
          r_btb[w_uidx].ctr    <= upd_uncond ? c_ctr_st : c_ctr_wt;
        end
      end else if (w_uhit) begin
        r_btb[w_uidx].valid <= 1'b0;
      end
    end
  end

  sat_counter #(.W(PERF_W)) u_perf_cf (
    .clk   (clk),
    .rst   (rst),
    .en    (upd_valid && upd_is_cf),
    .count (perf_cf)
  );

  sat_counter #(.W(PERF_W)) u_perf_miss (
    .clk   (clk),
    .rst   (rst),
    .en    (w_miss),
    .count (perf_miss)
  );

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_pred_unit : directed stimulus with a cycle-tagged scoreboard
// Rev 1.0
// ============================================================================
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_if = '0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0, upd_is_cf = 1'b0, upd_uncond = 1'b0;
  logic        upd_taken = 1'b0, upd_pred_taken = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0, upd_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc, perf_cf, perf_miss;

  branch_pred_unit dut (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cf(upd_is_cf),
    .upd_uncond(upd_uncond), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_cf(perf_cf), .perf_miss(perf_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    string       name;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    int          cyc;
    logic [31:0] rpc;
  } mp_t;

  localparam int K_HIT = 0, K_TAKEN = 1, K_TGT = 2, K_CF = 3, K_MISS = 4, K_RPC = 5;

  chk_t q[$];
  mp_t  mq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] sel(input int k);
    case (k)
      K_HIT:   return {31'd0, pred_hit};
      K_TAKEN: return {31'd0, pred_taken};
      K_TGT:   return pred_target;
      K_CF:    return perf_cf;
      K_MISS:  return perf_miss;
      default: return redirect_pc;
    endcase
  endfunction

  // Monitor: compares everything tagged for this cycle, and every mispredict pulse.
  initial forever begin
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc == cyc) begin
      chk_t c;
      c = q.pop_front();
      n_checks++;
      if (sel(c.kind) !== c.exp) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got %h, expected %h", c.name, cyc, sel(c.kind), c.exp);
      end
    end
    if (mispredict !== 1'b0 || (mq.size() > 0 && mq[0].cyc == cyc)) begin
      n_checks++;
      if (mq.size() > 0 && mq[0].cyc == cyc) begin
        mp_t m;
        m = mq.pop_front();
        if (mispredict !== 1'b1 || redirect_pc !== m.rpc) begin
          n_fail++;
          $display("FAIL redirect @cyc %0d: got mispredict=%b pc=%h, expected 1 pc=%h",
                   cyc, mispredict, redirect_pc, m.rpc);
        end
      end else begin
        n_fail++;
        $display("FAIL unexpected_mispredict @cyc %0d: got mispredict=%b pc=%h, expected 0",
                 cyc, mispredict, redirect_pc);
      end
    end
  end

  task automatic expect_out(input int k, input string nm, input logic [31:0] e);
    q.push_back('{cyc, k, nm, e});
  endtask

  task automatic expect_mp(input logic [31:0] rpc);
    mq.push_back('{cyc, rpc});
  endtask

  task automatic upd(input logic [31:0] pc, input logic cf, input logic unc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_is_cf = cf; upd_uncond = unc;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_is_cf = 1'b0; upd_pred_taken = 1'b0; upd_taken = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held: outputs forced to zero, update ignored.
    pc_if = 32'h100;
    upd(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    expect_out(K_HIT, "rst_hit", 0);
    expect_out(K_TAKEN, "rst_taken", 0);
    expect_out(K_TGT, "rst_target", 0);
    expect_out(K_RPC, "rst_redirect", 0);
    step();
    rst = 1'b0;

    // 1: clean lookup after reset
    pc_if = 32'h100;
    expect_out(K_HIT, "t1_hit", 0);
    expect_out(K_TAKEN, "t1_taken", 0);
    expect_out(K_CF, "t1_perf_cf", 0);
    expect_out(K_MISS, "t1_perf_miss", 0);
    step();

    // 2: allocate on taken miss
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_mp(32'h80);
    step();
    expect_out(K_MISS, "t2_perf_miss", 1);
    expect_out(K_CF, "t2_perf_cf", 1);
    expect_out(K_HIT, "t2_hit", 1);
    expect_out(K_TAKEN, "t2_taken", 1);
    expect_out(K_TGT, "t2_target", 32'h80);

    // 3: three not-taken updates, counter 10 -> 01 -> 00 -> 00
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    expect_mp(32'h104);
    step();
    expect_out(K_TAKEN, "t3_taken_after1", 0);
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    step();
    upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
    step();
    expect_out(K_HIT, "t3_hit", 1);
    expect_out(K_TAKEN, "t3_taken_sat", 0);
    expect_out(K_CF, "t3_perf_cf", 4);
    expect_out(K_MISS, "t3_perf_miss", 2);
    // From 00 one taken update only reaches 01: still not taken.
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_mp(32'h80);
    step();
    expect_out(K_TAKEN, "t3_taken_floor", 0);
    step();

    // 4: eviction on same index
    do_reset();
    upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    expect_mp(32'h80);
    step();
    upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    expect_mp(32'h300);
    step();
    pc_if = 32'h100;
    expect_out(K_HIT, "t4_evicted_hit", 0);
    step();
    pc_if = 32'h200;
    expect_out(K_HIT, "t4_new_hit", 1);
    expect_out(K_TAKEN, "t4_new_taken", 1);
    expect_out(K_TGT, "t4_new_target", 32'h300);
    step();

    // 5: no bypass of a same-cycle update
    pc_if = 32'h40;
    upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    expect_mp(32'h500);
    expect_out(K_HIT, "t5_same_cycle_hit", 0);
    step();
    expect_out(K_HIT, "t5_next_hit", 1);
    expect_out(K_TGT, "t5_next_target", 32'h500);
    step();

    // 6: jal then stale entry on a non-CF instruction
    do_reset();
    pc_if = 32'h40;
    upd(32'h40, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    expect_mp(32'h400);
    expect_out(K_HIT, "t6_pre_hit", 0);
    step();
    expect_out(K_HIT, "t6_jal_hit", 1);
    expect_out(K_TAKEN, "t6_jal_taken", 1);
    expect_out(K_TGT, "t6_jal_target", 32'h400);
    upd(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h400);
    expect_mp(32'h44);
    step();
    expect_out(K_HIT, "t6_invalidated", 0);
    expect_out(K_CF, "t6_perf_cf", 1);
    expect_out(K_MISS, "t6_perf_miss", 2);
    step();

    // Wrong-target case and a fully correct prediction.
    upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    expect_mp(32'h400);
    step();
    upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h480, 1'b1, 32'h400);
    expect_mp(32'h480);
    step();
    expect_out(K_TGT, "tgt_updated", 32'h480);
    upd(32'h40, 1'b1, 1'b0, 1'b1, 32'h480, 1'b1, 32'h480);
    step();
    expect_out(K_MISS, "final_perf_miss", 4);
    expect_out(K_CF, "final_perf_cf", 4);
    step();
    step();

    if (q.size() != 0 || mq.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size() + mq.size());
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
    end
  end

endmodule
`default_nettype wire
